updown_counter_mod: RTL

Parametrised successor to the team's 4-bit up/down counter. It adds:
- configurable width and terminal value (modulus)
- programmable step size
- synchronous load and clear
- wrap or saturate mode
- terminal-count indicators, an event pulse and a sticky event flag

Used for decade/BCD digit chains, PWM period counters and cyclic address generators on the PyNQ-Z1 fabric.

---
 rtl/updown_counter_mod.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/updown_counter_mod.sv
// ---------------------------------------------------------------------------
// updown_counter_mod
//   Parametrised up/down counter with a programmable step, terminal value
//   MAX_VAL, and either modulo (MAX_VAL+1) wrap-around or clamping at
//   0 / MAX_VAL. Any wrap or clamp is an "event". It produces a registered
//   one-cycle pulse and a sticky flag that only clr or rst clears.
//
//   Parameters
//     WIDTH    : counter width in bits (2..32)
//     MAX_VAL  : terminal value, 1 <= MAX_VAL <= 2**WIDTH-1
//     SATURATE : 0 = wrap modulo MAX_VAL+1, 1 = clamp at the range ends
//
//   Ports
//     clk          : clock, rising edge
//     rst          : asynchronous active-high reset
//     clr          : synchronous clear of count and event flags (highest prio)
//     load         : synchronous load of d_in (values above MAX_VAL clamp)
//     d_in         : load value
//     enable       : count enable
//     up_down      : 1 = count up, 0 = count down
//     step         : amount per enabled cycle, 0 = hold
//     count        : registered count, always within 0..MAX_VAL
//     at_max       : count == MAX_VAL
//     at_min       : count == 0
//     event_pulse  : high for the cycle after an edge that wrapped or clamped
//     event_sticky : set by any event, cleared by clr or rst
// ---------------------------------------------------------------------------
module updown_counter_mod #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             enable,
    input  logic             up_down,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             event_pulse,
    output logic             event_sticky
);

    // All range arithmetic uses one extra bit. The modulus MAX_VAL+1 can then
    // reach 2**WIDTH, and count+step cannot overflow.
    localparam logic [WIDTH:0] LP_MAX = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] LP_MOD = LP_MAX + {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_event_pulse;
    logic             r_event_sticky;

    logic [WIDTH:0]   w_cnt_ext;
    logic [WIDTH:0]   w_step_ext;

    // Up path
    logic [WIDTH:0]   w_up_sum;
    logic             w_up_ovf;
    logic [WIDTH:0]   w_up_wrap;
    logic [WIDTH-1:0] w_up_wrap_cl;

    // Down path
    logic             w_dn_unf;
    logic [WIDTH-1:0] w_dn_diff;
    logic [WIDTH:0]   w_dn_wrap;
    logic [WIDTH-1:0] w_dn_wrap_cl;

    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_next;
    logic             w_event;

    assign w_cnt_ext  = {1'b0, r_count};
    assign w_step_ext = {1'b0, step};

    assign w_up_sum  = w_cnt_ext + w_step_ext;
    assign w_up_ovf  = (w_up_sum > LP_MAX);
    assign w_up_wrap = w_up_sum - LP_MOD;

    assign w_dn_unf  = (step > r_count);
    assign w_dn_diff = r_count - step;
    // Only used when step > count. The result then lies in
    // MAX_VAL+1-step .. MAX_VAL.
    assign w_dn_wrap = w_cnt_ext + LP_MOD - w_step_ext;

    // With a legal step (<= MAX_VAL), the wrapped results are always in range.
    // An illegal step could push them past MAX_VAL. Clamp them so the count
    // register never holds an out-of-range value, whatever step is.
    assign w_up_wrap_cl = (w_up_wrap > LP_MAX) ? MAX_VAL : w_up_wrap[WIDTH-1:0];
    assign w_dn_wrap_cl = (w_dn_wrap > LP_MAX) ? MAX_VAL : w_dn_wrap[WIDTH-1:0];

    assign w_load_val = (d_in > MAX_VAL) ? MAX_VAL : d_in;

    // Next-state selection: clr > load > enable > hold
    always_comb begin
        w_next  = r_count;
        w_event = 1'b0;
        if (clr) begin
            w_next = '0;
        end else if (load) begin
            w_next = w_load_val;
        end else if (enable) begin
            if (up_down) begin
                if (w_up_ovf) begin
                    w_event = 1'b1;
                    w_next  = SATURATE ? MAX_VAL : w_up_wrap_cl;
                end else begin
                    w_next  = w_up_sum[WIDTH-1:0];
                end
            end else begin
                if (w_dn_unf) begin
                    w_event = 1'b1;
                    w_next  = SATURATE ? '0 : w_dn_wrap_cl;
                end else begin
                    w_next  = w_dn_diff;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count        <= '0;
            r_event_pulse  <= 1'b0;
            r_event_sticky <= 1'b0;
        end else begin
            r_count        <= w_next;
            r_event_pulse  <= w_event;
            r_event_sticky <= clr ? 1'b0 : (r_event_sticky | w_event);
        end
    end

    assign count        = r_count;
    assign at_max       = (r_count == MAX_VAL);
    assign at_min       = (r_count == '0);
    assign event_pulse  = r_event_pulse;
    assign event_sticky = r_event_sticky;

endmodule
